lfsr_req_scheduler: RTL
=======================

# lfsr_req_scheduler

Round-robin scheduler that shares one `LFSR_core` among `NUM_REQ` consumers of random bytes. It grants the generator to one requester at a time for a burst of 1–16 bytes. It drives the core's `enable` so that every byte accepted by the owner is a distinct LFSR state. It sits between `LFSR_core.lfsr_out`/`enable` and the consumer blocks, beside the AXI-lite register slave, which still owns seed, taps and load.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `LEN_W`, default 4: width of the per-requester burst length field. Burst is `len+1` bytes.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester request level. Held high until burst end.
- `req_len` in `NUM_REQ*LEN_W`: burst length minus one. Requester i uses bits `[i*LEN_W +: LEN_W]`.
- `gnt` out `NUM_REQ`: one-hot grant to the current burst owner.
- `rnd_ready` in `NUM_REQ`: per-requester ready. Only the owner's bit is used.
- `rnd_valid` out 1: byte available to the owner.
- `rnd_data` out 8: equals `lfsr_data` (combinational pass-through).
- `rnd_last` out 1: final byte of the burst.
- `lfsr_enable` out 1: to `LFSR_core.enable`.
- `lfsr_data` in 8: from `LFSR_core.lfsr_out`.
- `busy` out 1: a burst is in progress.
- `bytes_served` out 16: count of accepted bytes since reset. Wraps from 0xFFFF to 0x0000.

## Operation
- States: IDLE and STREAM.
- **IDLE**
  - `gnt`, `rnd_valid` and `lfsr_enable` are 0.
  - If any `req` bit is set, select the winner by round-robin, searching from `ptr+1` upward modulo `NUM_REQ`.
  - Register `gnt`, set owner = winner, load `cnt` = `req_len[owner]`, set `busy` = 1, go to STREAM.
  - If `req` is all zero, stay in IDLE.
- **STREAM**
  - `rnd_valid` = 1.
  - `rnd_last` = (`cnt` == 0).
  - Handshake = `rnd_valid` & `rnd_ready[owner]`.
  - `lfsr_enable` = handshake, so the core advances exactly once per accepted byte.
  - On handshake, `bytes_served` increments.
  - Handshake with `cnt` == 0: next state IDLE, clear `gnt` and `busy`, set `ptr` = owner.
  - Handshake with `cnt` != 0: decrement `cnt`.
  - No handshake: hold `cnt`. `rnd_data` stays stable because the LFSR is not enabled.
- **Abort**: `req[owner]` low in STREAM without a handshake that cycle.
  - Next state IDLE, `ptr` = owner.
  - No `rnd_last` is issued and `lfsr_enable` stays 0.
  - A handshake in the same cycle as the drop is completed and counted, then the burst aborts.
- `req_len` is sampled only at grant. Later changes do not affect the current burst.
- `req` changes from non-owners during STREAM are ignored until the next arbitration.
- `ptr` update rule is fixed: it takes the owner's index whenever a burst ends, whether completed or aborted.
- The LFSR stuck-at-zero recovery, load and reset behaviour belong to the core. The scheduler treats `lfsr_data` as opaque.

## Timing
- Values while `resetn` is low, applied asynchronously:
  - state IDLE, `ptr` = `NUM_REQ-1` (so requester 0 wins first), `cnt` = 0.
  - `gnt`, `rnd_valid`, `rnd_last`, `lfsr_enable`, `busy` all 0; `bytes_served` = 0.
- Release of `resetn` is synchronous to `clk`.
- Latency: `req` high at edge N gives `gnt` and `rnd_valid` high after edge N+1.
- Burst of L bytes with `rnd_ready` constantly high: L consecutive cycles of `rnd_valid`, then 1 mandatory IDLE cycle before the next grant.
- `lfsr_enable` and `rnd_valid` never assert in IDLE.
- `gnt` is at most one-hot at all times.
- Reset asserted mid-burst: `gnt` and `rnd_valid` drop immediately and the burst is lost. The first grant after reset goes to the lowest requesting index ≥ 0.

## Test plan
- **Reset**: assert `resetn`=0 mid-burst → all outputs 0 without waiting for a clock edge. After release with `req`=0b0101 → `gnt`=0b0001 first.
- **Single burst**: core seeded 0xA5 with taps 0xB4, `req[0]`=1, `req_len[0]`=3, ready always high.
  - `rnd_data` sequence: 0xA5, 0x4B, 0x96, 0x2D.
  - `rnd_last` high only on 0x2D; `lfsr_enable` high exactly 4 cycles; `bytes_served`=4.
- **Fairness**: `req`=0b1111 held, all `req_len`=0 → grants 0,1,2,3,0 in order, each 1-cycle burst followed by 1 idle cycle.
- **Backpressure**: 4-byte burst with `rnd_ready[owner]` low for 3 cycles after byte 2.
  - `rnd_data` holds 0x96, `lfsr_enable` stays 0, `cnt` holds.
  - Burst resumes and delivers 0x2D as last.
- **Abort**: `req[1]` drops after 2 of 8 bytes.
  - Next cycle: `gnt`=0, `rnd_valid`=0, no `rnd_last`; `bytes_served` +2.
  - With `req`=0b0011 pending, the next grant goes to requester 0.
- **Wrap**: force `bytes_served`=0xFFFF, then accept 1 byte → 0x0000.

Source files
------------

// File: rtl/lfsr_req_scheduler.sv
// Round-robin arbiter sharing one LFSR core among NUM_REQ byte consumers.
// Grants bursts of req_len+1 bytes and advances the core once per accepted byte.
module lfsr_req_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ-1:0]       rnd_ready,
  output logic                     rnd_valid,
  output logic [7:0]               rnd_data,
  output logic                     rnd_last,
  output logic                     lfsr_enable,
  input  logic [7:0]               lfsr_data,
  output logic                     busy,
  output logic [15:0]              bytes_served
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [LEN_W-1:0]   win_len;
  logic               hs;
  logic               burst_end;

  assign rnd_data = lfsr_data;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rnd_valid   = 1'b0;
    rnd_last    = 1'b0;
    lfsr_enable = 1'b0;
    hs          = 1'b0;
    burst_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        rnd_valid   = 1'b1;
        rnd_last    = (cnt_q == '0);
        hs          = rnd_ready[owner_q];
        lfsr_enable = hs;
        // A dropped request ends the burst even if its final handshake lands.
        burst_end   = (hs && (cnt_q == '0)) || !req[owner_q];
        if (burst_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      gnt          <= '0;
      busy         <= 1'b0;
      bytes_served <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        bytes_served <= bytes_served + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (win_found) begin
            owner_q <= win_idx;
            gnt     <= NUM_REQ'(1) << win_idx;
            cnt_q   <= win_len;
            busy    <= 1'b1;
          end
        end
        STREAM: begin
          if (burst_end) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr_q <= owner_q;
          end else if (hs) begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
